// File: rtl/aes_uart_pkg.sv
// Shared definitions for the AES result UART transmitter: FSM encoding,
// default timing and a counter-width helper.
package aes_uart_pkg;

   localparam int CLKS_PER_BIT_DEF = 868;
   localparam int NUM_BYTES_DEF    = 16;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // Width of a counter holding 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/aes_result_uart_tx_if.sv
// Result bus from the AES core into the UART framer, plus the serial line
// and status flags coming back out.
interface aes_result_uart_tx_if #(
   parameter int NUM_BYTES = aes_uart_pkg::NUM_BYTES_DEF
);
   logic                   result_valid;
   logic [NUM_BYTES*8-1:0] result_data;
   logic                   tx;
   logic                   busy;
   logic                   tx_done;
   logic                   overrun;

   modport master (
      output result_valid,
      output result_data,
      input  tx,
      input  busy,
      input  tx_done,
      input  overrun
   );

   modport slave (
      input  result_valid,
      input  result_data,
      output tx,
      output busy,
      output tx_done,
      output overrun
   );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, eight data bits LSB first, stop bit, each held
// CLKS_PER_BIT cycles; chains straight into the next start bit when more bytes follow.
module uart_tx_byte
   import aes_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       more,
   input  logic [7:0] data,
   output logic       tx,
   output logic       load,
   output logic       stop_end,
   output state_t     state
);
   localparam int                BAUD_W    = cnt_width(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   state_t            state_reg, state_next;
   logic [BAUD_W-1:0] baud_reg, baud_next;
   logic [2:0]        bit_reg, bit_next;
   logic [7:0]        shreg_reg, shreg_next;
   logic              tx_reg, tx_next;
   logic              bit_tick;

   assign bit_tick = (baud_reg == BAUD_LAST);

   always_comb begin
      state_next = state_reg;
      baud_next  = bit_tick ? '0 : baud_reg + 1'b1;
      bit_next   = bit_reg;
      shreg_next = shreg_reg;
      tx_next    = tx_reg;
      case (state_reg)
         ST_IDLE: begin
            baud_next = '0;
            if (start) begin
               state_next = ST_START;
               bit_next   = '0;
               tx_next    = 1'b0;
            end
         end
         // The byte is sampled at the end of its start bit, so the caller
         // only has to present it by then.
         ST_START: begin
            if (bit_tick) begin
               state_next = ST_DATA;
               bit_next   = '0;
               shreg_next = data;
               tx_next    = data[0];
            end
         end
         ST_DATA: begin
            if (bit_tick) begin
               if (bit_reg == 3'd7) begin
                  state_next = ST_STOP;
                  tx_next    = 1'b1;
               end else begin
                  bit_next   = bit_reg + 3'd1;
                  shreg_next = shreg_reg >> 1;
                  tx_next    = shreg_reg[1];
               end
            end
         end
         ST_STOP: begin
            if (bit_tick) begin
               if (more) begin
                  state_next = ST_START;
                  tx_next    = 1'b0;
               end else begin
                  state_next = ST_IDLE;
                  tx_next    = 1'b1;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         baud_reg  <= '0;
         bit_reg   <= '0;
         shreg_reg <= '0;
         tx_reg    <= 1'b1;
      end else begin
         state_reg <= state_next;
         baud_reg  <= baud_next;
         bit_reg   <= bit_next;
         shreg_reg <= shreg_next;
         tx_reg    <= tx_next;
      end
   end

   assign tx       = tx_reg;
   assign state    = state_reg;
   assign load     = (state_reg == ST_START) && bit_tick;
   assign stop_end = (state_reg == ST_STOP) && bit_tick;

endmodule

// File: rtl/aes_result_uart_tx.sv
// Captures one AES result block and streams it out over UART, most significant
// byte first, with busy / tx_done / sticky overrun status.
module aes_result_uart_tx
   import aes_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int NUM_BYTES    = NUM_BYTES_DEF
) (
   input logic                 clk,
   input logic                 rst,
   aes_result_uart_tx_if.slave bus
);
   localparam int                DATA_W    = NUM_BYTES * 8;
   localparam int                BYTE_W    = cnt_width(NUM_BYTES);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

   logic [DATA_W-1:0] shift_reg, shift_next, shift_adv;
   logic [BYTE_W-1:0] byte_idx_reg, byte_idx_next;
   logic              busy_reg, busy_next;
   logic              tx_done_reg, tx_done_next;
   logic              overrun_reg, overrun_next;
   logic              armed_reg;

   state_t ser_state;
   logic   ser_tx, ser_load, ser_stop_end;
   logic   capture, more;

   // armed_reg masks the first edge after reset release so a stale pulse
   // coinciding with release is not taken as a result.
   assign capture = armed_reg && bus.result_valid && (ser_state == ST_IDLE);
   assign more    = (byte_idx_reg != BYTE_LAST);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
         if (gi == 0) begin : g_fill
            assign shift_adv[7:0] = 8'h00;
         end else begin : g_move
            assign shift_adv[gi*8 +: 8] = shift_reg[(gi-1)*8 +: 8];
         end
      end
   endgenerate

   always_comb begin
      shift_next    = shift_reg;
      byte_idx_next = byte_idx_reg;
      busy_next     = busy_reg;
      tx_done_next  = 1'b0;
      overrun_next  = overrun_reg;
      if (capture) begin
         shift_next    = bus.result_data;
         byte_idx_next = '0;
         busy_next     = 1'b1;
      end else if (ser_load) begin
         shift_next = shift_adv;
      end
      if (ser_stop_end) begin
         if (more) begin
            byte_idx_next = byte_idx_reg + 1'b1;
         end else begin
            busy_next    = 1'b0;
            tx_done_next = 1'b1;
         end
      end
      if (bus.result_valid && (ser_state != ST_IDLE)) begin
         overrun_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_reg    <= '0;
         byte_idx_reg <= '0;
         busy_reg     <= 1'b0;
         tx_done_reg  <= 1'b0;
         overrun_reg  <= 1'b0;
         armed_reg    <= 1'b0;
      end else begin
         shift_reg    <= shift_next;
         byte_idx_reg <= byte_idx_next;
         busy_reg     <= busy_next;
         tx_done_reg  <= tx_done_next;
         overrun_reg  <= overrun_next;
         armed_reg    <= 1'b1;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk     (clk),
      .rst     (rst),
      .start   (capture),
      .more    (more),
      .data    (shift_reg[DATA_W-1 -: 8]),
      .tx      (ser_tx),
      .load    (ser_load),
      .stop_end(ser_stop_end),
      .state   (ser_state)
   );

   assign bus.tx      = ser_tx;
   assign bus.busy    = busy_reg;
   assign bus.tx_done = tx_done_reg;
   assign bus.overrun = overrun_reg;

endmodule

// File: tb/tb_aes_result_uart_tx.sv
// Self-checking bench for aes_result_uart_tx at CLKS_PER_BIT=4: table vectors,
// random frames against a bit-slot model, and hand-written corner sequences.
module tb_aes_result_uart_tx;

   localparam int CPB   = 4;
   localparam int NB    = 16;
   localparam int FRAME = NB * 10 * CPB;

   typedef struct {
      logic [127:0] data;
      logic [7:0]   first_byte;
      logic [7:0]   last_byte;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   int           n_cmp = 0;
   int           n_bad = 0;
   logic [127:0] last_dec;

   logic obs_tx   [0:FRAME+1];
   logic obs_busy [0:FRAME+1];
   logic obs_done [0:FRAME+1];
   logic obs_ovr  [0:FRAME+1];

   aes_result_uart_tx_if #(.NUM_BYTES(NB)) dut_bus ();

   aes_result_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .NUM_BYTES   (NB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(dut_bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required normal finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_int(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Model: cycle k after capture lies in bit slot (k-1)/CPB; ten slots per byte.
   function automatic logic exp_tx(input logic [127:0] d, input int k);
      int         slot;
      int         byte_i;
      int         bit_slot;
      logic [7:0] b;
      if (k < 1 || k > FRAME) return 1'b1;
      slot     = (k - 1) / CPB;
      byte_i   = slot / 10;
      bit_slot = slot % 10;
      b        = d[127 - 8*byte_i -: 8];
      if (bit_slot == 0) return 1'b0;
      if (bit_slot == 9) return 1'b1;
      return b[bit_slot - 1];
   endfunction

   // Independent UART receiver: find a falling level, sample mid-bit.
   task automatic decode(output logic [127:0] val, output int nbytes);
      int         i;
      logic [7:0] b;
      val    = '0;
      nbytes = 0;
      i      = 1;
      while (i + 10*CPB - 1 <= FRAME + 1 && nbytes < NB) begin
         if (obs_tx[i] == 1'b0) begin
            for (int j = 0; j < 8; j++) b[j] = obs_tx[i + CPB*(j+1) + CPB/2];
            if (obs_tx[i + CPB/2] == 1'b0 && obs_tx[i + 9*CPB + CPB/2] == 1'b1) begin
               val = {val[119:0], b};
               nbytes++;
            end
            i = i + 9*CPB + CPB/2 + 1;
         end else begin
            i++;
         end
      end
   endtask

   task automatic launch(input string name, input logic [127:0] d);
      @(negedge clk);
      check_int({name, " idle_tx"}, int'(dut_bus.tx), 1);
      dut_bus.result_valid = 1'b1;
      dut_bus.result_data  = d;
   endtask

   // Entered with the capture pulse already driven for the coming edge.
   task automatic run_frame(input string name, input logic [127:0] d, input bit toggle,
                            input int inject_k, input bit chain, input logic [127:0] next_d);
      int           tx_err;
      int           busy_err;
      int           done_cnt;
      int           done_at;
      int           last_busy;
      int           nbytes;
      logic         eb;
      logic [127:0] dec;
      tx_err = 0; busy_err = 0; done_cnt = 0; done_at = -1; last_busy = 0;
      for (int k = 1; k <= FRAME + 1; k++) begin
         @(negedge clk);
         obs_tx[k]   = dut_bus.tx;
         obs_busy[k] = dut_bus.busy;
         obs_done[k] = dut_bus.tx_done;
         obs_ovr[k]  = dut_bus.overrun;
         dut_bus.result_valid = (k == inject_k) || (chain && k == FRAME + 1);
         if (chain && k == FRAME + 1) dut_bus.result_data = next_d;
         else if (toggle || k == inject_k) dut_bus.result_data = rand128();
      end
      for (int k = 1; k <= FRAME + 1; k++) begin
         eb = (k <= FRAME);
         if (obs_tx[k] !== exp_tx(d, k)) tx_err++;
         if (obs_busy[k] !== eb) busy_err++;
         if (obs_busy[k] === 1'b1) last_busy = k;
         if (obs_done[k] === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
      end
      check_int({name, " tx_wave_errs"}, tx_err, 0);
      check_int({name, " busy_errs"}, busy_err, 0);
      check_int({name, " frame_len"}, last_busy, FRAME);
      check_int({name, " tx_done_cycle"}, done_at, FRAME + 1);
      check_int({name, " tx_done_count"}, done_cnt, 1);
      decode(dec, nbytes);
      check_int({name, " byte_count"}, nbytes, NB);
      check_vec({name, " decoded"}, dec, d);
      last_dec = dec;
      $display("frame %-12s data=%h decoded=%h bytes=%0d", name, d, dec, nbytes);
   endtask

   initial begin
      vec_t         vecs [4];
      logic [9:0]   seq69;
      logic [39:0]  exp40;
      logic [39:0]  obs40;
      logic [127:0] d1;
      logic [127:0] d2;

      vecs[0] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 8'h69, 8'h5a};
      vecs[1] = '{128'h0, 8'h00, 8'h00};
      vecs[2] = '{{128{1'b1}}, 8'hff, 8'hff};
      vecs[3] = '{128'h00112233445566778899aabbccddeeff, 8'h00, 8'hff};
      seq69   = 10'b1011010010;

      dut_bus.result_valid = 1'b0;
      dut_bus.result_data  = '0;
      repeat (3) @(negedge clk);
      check_int("reset tx", int'(dut_bus.tx), 1);
      check_int("reset busy", int'(dut_bus.busy), 0);
      check_int("reset tx_done", int'(dut_bus.tx_done), 0);
      check_int("reset overrun", int'(dut_bus.overrun), 0);
      rst = 1'b1;

      for (int i = 0; i < 4; i++) begin
         launch($sformatf("vec%0d", i), vecs[i].data);
         run_frame($sformatf("vec%0d", i), vecs[i].data, 1'b0, 0, 1'b0, '0);
         check_vec($sformatf("vec%0d first_byte", i), {120'h0, last_dec[127:120]}, {120'h0, vecs[i].first_byte});
         check_vec($sformatf("vec%0d last_byte", i), {120'h0, last_dec[7:0]}, {120'h0, vecs[i].last_byte});
         check_int($sformatf("vec%0d overrun", i), int'(obs_ovr[FRAME+1]), 0);
         if (i == 0) begin
            for (int k = 0; k < 40; k++) begin
               exp40[k] = seq69[k / CPB];
               obs40[k] = obs_tx[k + 1];
            end
            check_vec("first_byte_seq", {88'h0, obs40}, {88'h0, exp40});
         end
      end

      for (int i = 0; i < 3; i++) begin
         d1 = rand128();
         launch($sformatf("rand%0d", i), d1);
         run_frame($sformatf("rand%0d", i), d1, (i == 2), 0, 1'b0, '0);
      end

      d1 = rand128();
      d2 = rand128();
      launch("b2b_a", d1);
      run_frame("b2b_a", d1, 1'b0, 0, 1'b1, d2);
      run_frame("b2b_b", d2, 1'b0, 0, 1'b0, '0);
      check_int("b2b overrun", int'(dut_bus.overrun), 0);

      d1 = rand128();
      launch("overrun", d1);
      run_frame("overrun", d1, 1'b0, 100, 1'b0, '0);
      check_int("overrun at 100", int'(obs_ovr[100]), 0);
      check_int("overrun at 101", int'(obs_ovr[101]), 1);
      check_int("overrun at end", int'(obs_ovr[FRAME+1]), 1);
      repeat (5) @(negedge clk);
      check_int("overrun sticky", int'(dut_bus.overrun), 1);

      d1 = vecs[0].data;
      launch("reset_mid", d1);
      for (int k = 1; k <= 250; k++) begin
         @(negedge clk);
         dut_bus.result_valid = 1'b0;
      end
      check_int("pre-reset tx", int'(dut_bus.tx), int'(exp_tx(d1, 250)));
      check_int("pre-reset busy", int'(dut_bus.busy), 1);
      check_int("pre-reset overrun", int'(dut_bus.overrun), 1);
      #1 rst = 1'b0;
      #1;
      check_int("mid-reset tx", int'(dut_bus.tx), 1);
      check_int("mid-reset busy", int'(dut_bus.busy), 0);
      check_int("mid-reset overrun", int'(dut_bus.overrun), 0);
      check_int("mid-reset tx_done", int'(dut_bus.tx_done), 0);
      repeat (3) @(negedge clk);
      check_int("held-reset tx", int'(dut_bus.tx), 1);
      rst = 1'b1;

      d2 = rand128();
      launch("post_reset", d2);
      run_frame("post_reset", d2, 1'b0, 0, 1'b0, '0);
      check_int("post_reset overrun", int'(obs_ovr[FRAME+1]), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
